mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. load/store, single-cycle memory.
// Define MEM_ARB_RR_EN to alternate grants on simultaneous requests instead of fixed ls priority.
module mem_arbiter #(
  parameter int unsigned M_WIDTH = 32,
  parameter int unsigned A_WIDTH = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [A_WIDTH-1:0]   if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  input  logic                 ls_req,
  input  logic [A_WIDTH-1:0]   ls_addr,
  input  logic [M_WIDTH/8-1:0] ls_wes,
  input  logic [M_WIDTH-1:0]   ls_wdata,
  input  logic                 ls_lock,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [M_WIDTH-1:0]   rdata,
  output logic [A_WIDTH-1:0]   mem_addr,
  output logic [M_WIDTH/8-1:0] mem_wes,
  output logic [M_WIDTH-1:0]   mem_wdata,
  input  logic [M_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned S_WIDTH = M_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_OWN    = 2'd1,
    LS_LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [A_WIDTH-1:0] addr_q;
  logic               if_rvalid_q;
  logic               ls_rvalid_q;
  logic               ls_first;

`ifdef MEM_ARB_RR_EN
  // Remembers whether ls won the most recent grant; ls goes first after reset.
  logic last_ls_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls_q <= 1'b0;
    end else if (if_gnt || ls_gnt) begin
      last_ls_q <= ls_gnt;
    end
  end

  assign ls_first = ~last_ls_q;
`else
  assign ls_first = 1'b1;
`endif

  // Owner state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decision and owner next state; grants are forced low while in reset.
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    if (rst) begin
      case (state_q)
        LS_LOCKED: begin
          ls_gnt = ls_req;
          if (!ls_lock) begin
            state_d = IDLE;
          end
        end
        default: begin
          if (ls_req && (!if_req || ls_first)) begin
            ls_gnt = 1'b1;
          end else if (if_req) begin
            if_gnt = 1'b1;
          end
          if (ls_gnt) begin
            state_d = ls_lock ? LS_LOCKED : IDLE;
          end else if (if_gnt) begin
            state_d = IF_OWN;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // Command port: granted requester's command, otherwise hold the last address.
  always_comb begin
    mem_addr  = addr_q;
    mem_wes   = S_WIDTH'(0);
    mem_wdata = ls_wdata;
    if (ls_gnt) begin
      mem_addr = ls_addr;
      mem_wes  = ls_wes;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= A_WIDTH'(0);
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      addr_q      <= mem_addr;
      if_rvalid_q <= if_gnt;
      ls_rvalid_q <= ls_gnt;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model with a shadow memory.
module tb_mem_arbiter;

  localparam int unsigned M_WIDTH = 32;
  localparam int unsigned A_WIDTH = 30;
  localparam int unsigned S_WIDTH = M_WIDTH / 8;
  localparam int unsigned DEPTH   = 64;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               if_req = 1'b0;
  logic [A_WIDTH-1:0] if_addr = '0;
  logic               if_gnt, if_rvalid;
  logic               ls_req = 1'b0;
  logic [A_WIDTH-1:0] ls_addr = '0;
  logic [S_WIDTH-1:0] ls_wes = '0;
  logic [M_WIDTH-1:0] ls_wdata = '0;
  logic               ls_lock = 1'b0;
  logic               ls_gnt, ls_rvalid;
  logic [M_WIDTH-1:0] rdata;
  logic [A_WIDTH-1:0] mem_addr;
  logic [S_WIDTH-1:0] mem_wes;
  logic [M_WIDTH-1:0] mem_wdata;
  logic [M_WIDTH-1:0] mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.M_WIDTH(M_WIDTH), .A_WIDTH(A_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wes(ls_wes), .ls_wdata(ls_wdata),
    .ls_lock(ls_lock), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wes(mem_wes), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous memory: registered read of the old word, byte writes, plus a backdoor port.
  logic [M_WIDTH-1:0] mem_array [DEPTH] = '{default: '0};
  logic               bd_we = 1'b0;
  logic [5:0]         bd_idx = '0;
  logic [M_WIDTH-1:0] bd_data = '0;

  always @(posedge clk) begin
    mem_rdata <= mem_array[mem_addr[5:0]];
    for (int b = 0; b < int'(S_WIDTH); b++)
      if (mem_wes[b]) mem_array[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (bd_we) mem_array[bd_idx] <= bd_data;
  end

  // Reference model state
  logic [M_WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
  bit                 m_locked;
  bit                 m_prefer_ls;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_addr = '0;
    ls_wes = '0; ls_wdata = '0; ls_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
    m_locked    = 1'b0;
    m_prefer_ls = 1'b1;
  endtask

  task automatic preload(input int idx, input logic [M_WIDTH-1:0] d);
    bd_we = 1'b1; bd_idx = 6'(idx); bd_data = d;
    step();
    bd_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 30'h15; ls_req = 1'b1; ls_addr = 30'h22; ls_wes = 4'hF;
    step();
    n_cmp++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt got %b exp 0", if_gnt); end
    n_cmp++; if (ls_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ls_gnt got %b exp 0", ls_gnt); end
    n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_if_rvalid got %b exp 0", if_rvalid); end
    n_cmp++; if (ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_ls_rvalid got %b exp 0", ls_rvalid); end
    n_cmp++; if (mem_wes !== 4'h0) begin n_fail++; $display("FAIL reset_mem_wes got %h exp 0", mem_wes); end
    n_cmp++; if (mem_addr !== 30'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    clear_inputs();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    do_reset();
    preload(16, 32'h00A00513);
    if_req = 1'b1; if_addr = 30'h10;
    #1;
    n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt got %b exp 1", if_gnt); end
    n_cmp++; if (mem_addr !== 30'h10) begin n_fail++; $display("FAIL fetch_addr got %h exp 10", mem_addr); end
    n_cmp++; if (mem_wes !== 4'h0) begin n_fail++; $display("FAIL fetch_wes got %h exp 0", mem_wes); end
    step();
    n_cmp++; if (if_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid got %b exp 1", if_rvalid); end
    n_cmp++; if (rdata !== 32'h00A00513) begin n_fail++; $display("FAIL fetch_rdata got %h exp 00a00513", rdata); end
    if_req = 1'b0; if_addr = 30'h3;
    #1;
    n_cmp++; if (mem_addr !== 30'h10) begin n_fail++; $display("FAIL fetch_addr_hold got %h exp 10", mem_addr); end
    step();
    n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_drop got %b exp 0", if_rvalid); end
  endtask

  task automatic test_store();
    do_reset();
    preload(56, 32'h11223344);
    ls_req = 1'b1; ls_addr = 30'h38; ls_wes = 4'b0011; ls_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (ls_gnt !== 1'b1) begin n_fail++; $display("FAIL store_gnt got %b exp 1", ls_gnt); end
    n_cmp++; if (mem_wes !== 4'b0011) begin n_fail++; $display("FAIL store_wes got %h exp 3", mem_wes); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_wdata got %h exp deadbeef", mem_wdata); end
    step();
    n_cmp++; if (ls_rvalid !== 1'b1) begin n_fail++; $display("FAIL store_rvalid got %b exp 1", ls_rvalid); end
    n_cmp++; if (rdata !== 32'h11223344) begin n_fail++; $display("FAIL store_old_data got %h exp 11223344", rdata); end
    ls_wes = 4'b0000;
    #1;
    n_cmp++; if (ls_gnt !== 1'b1) begin n_fail++; $display("FAIL load_b2b_gnt got %b exp 1", ls_gnt); end
    step();
    n_cmp++; if (ls_rvalid !== 1'b1) begin n_fail++; $display("FAIL load_rvalid got %b exp 1", ls_rvalid); end
    n_cmp++; if (rdata !== 32'h1122BEEF) begin n_fail++; $display("FAIL load_merged got %h exp 1122beef", rdata); end
    clear_inputs();
    step();
  endtask

  task automatic test_contention();
    bit exp_ls;
    bit prev_ls;
    do_reset();
    if_req = 1'b1; if_addr = 30'h4; ls_req = 1'b1; ls_addr = 30'h8;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_ls = RR ? (i % 2 == 0) : 1'b1;
      n_cmp++; if (ls_gnt !== exp_ls) begin n_fail++; $display("FAIL contend_ls_gnt[%0d] got %b exp %b", i, ls_gnt, exp_ls); end
      n_cmp++; if (if_gnt !== !exp_ls) begin n_fail++; $display("FAIL contend_if_gnt[%0d] got %b exp %b", i, if_gnt, !exp_ls); end
      prev_ls = exp_ls;
      step();
      n_cmp++; if (ls_rvalid !== prev_ls) begin n_fail++; $display("FAIL contend_ls_rvalid[%0d] got %b exp %b", i, ls_rvalid, prev_ls); end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_lock();
    do_reset();
    if_req = 1'b1; if_addr = 30'h2; ls_req = 1'b1; ls_addr = 30'h6; ls_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ls_req = 1'b1;
      #1;
      n_cmp++; if (ls_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_ls_gnt[%0d] got %b exp 1", i, ls_gnt); end
      n_cmp++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_if_gnt[%0d] got %b exp 0", i, if_gnt); end
      step();
    end
    ls_req = 1'b0; ls_lock = 1'b0;
    #1;
    n_cmp++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_release_cycle got %b exp 0", if_gnt); end
    step();
    n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_after_release got %b exp 1", if_gnt); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1'b1; if_addr = 30'h5;
    #1;
    n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_gnt got %b exp 1", if_gnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt got %b exp 0", if_gnt); end
    n_cmp++; if (mem_addr !== 30'h0) begin n_fail++; $display("FAIL midrst_addr got %h exp 0", mem_addr); end
    step();
    n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_in got %b exp 0", if_rvalid); end
    if_req = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_after got %b exp 0", if_rvalid); end
  endtask

  task automatic test_random();
    bit                 e_if, e_ls, exp_if_rv, exp_ls_rv;
    logic [M_WIDTH-1:0] exp_rdata;
    logic [A_WIDTH-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    exp_if_rv = 1'b0; exp_ls_rv = 1'b0; exp_rdata = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      n_cmp++; if (if_rvalid !== exp_if_rv) begin n_fail++; $display("FAIL rnd_if_rvalid cyc %0d got %b exp %b", cyc, if_rvalid, exp_if_rv); end
      n_cmp++; if (ls_rvalid !== exp_ls_rv) begin n_fail++; $display("FAIL rnd_ls_rvalid cyc %0d got %b exp %b", cyc, ls_rvalid, exp_ls_rv); end
      if (exp_if_rv || exp_ls_rv) begin
        n_cmp++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", cyc, rdata, exp_rdata); end
      end
      if (!if_req) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = A_WIDTH'($urandom_range(0, 15));
      end
      if (!ls_req) begin
        ls_req   = ($urandom_range(0, 2) != 0);
        ls_addr  = A_WIDTH'($urandom_range(0, 15));
        ls_wes   = ($urandom_range(0, 1) != 0) ? S_WIDTH'($urandom) : '0;
        ls_wdata = $urandom;
      end
      ls_lock = ($urandom_range(0, 3) == 0);
      #1;
      // Expected winner from the arbitration rules
      if (m_locked) begin
        e_ls = ls_req; e_if = 1'b0;
      end else if (ls_req && if_req) begin
        e_ls = RR ? m_prefer_ls : 1'b1; e_if = !e_ls;
      end else begin
        e_ls = ls_req; e_if = if_req;
      end
      n_cmp++; if (if_gnt !== e_if) begin n_fail++; $display("FAIL rnd_if_gnt cyc %0d got %b exp %b", cyc, if_gnt, e_if); end
      n_cmp++; if (ls_gnt !== e_ls) begin n_fail++; $display("FAIL rnd_ls_gnt cyc %0d got %b exp %b", cyc, ls_gnt, e_ls); end
      if (e_ls || e_if) begin
        exp_addr = e_ls ? ls_addr : if_addr;
        n_cmp++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_mem_addr cyc %0d got %h exp %h", cyc, mem_addr, exp_addr); end
        n_cmp++; if (mem_wes !== (e_ls ? ls_wes : 4'h0)) begin n_fail++; $display("FAIL rnd_mem_wes cyc %0d got %h exp %h", cyc, mem_wes, e_ls ? ls_wes : 4'h0); end
      end
      exp_if_rv = e_if; exp_ls_rv = e_ls;
      if (e_ls) begin
        exp_rdata = ref_mem[ls_addr[5:0]];
        for (int b = 0; b < int'(S_WIDTH); b++)
          if (ls_wes[b]) ref_mem[ls_addr[5:0]][8*b +: 8] = ls_wdata[8*b +: 8];
      end else if (e_if) begin
        exp_rdata = ref_mem[if_addr[5:0]];
      end
      m_locked = m_locked ? ls_lock : (e_ls && ls_lock);
      if (e_ls || e_if) m_prefer_ls = e_if;
      step();
      if (e_if) if_req = 1'b0;
      if (e_ls) ls_req = 1'b0;
    end
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_lock();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
